alu_ctrl_seq: RTL

ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

---
 rtl/alu_ctrl_seq.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_ctrl_seq
// Brief    : ALU control decoder with an optional iterative multiply/divide
//            unit (MUL/DIVU/REMU), enabled by defining ALU_CTRL_MDU_EN.
// Revision : 1.0 - initial release
// ============================================================================
module alu_ctrl_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       ALUOp,
    input  logic [6:0]       funct7,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             out_valid,
    output logic [3:0]       operation,
    output logic             md_sel,
    output logic [WIDTH-1:0] md_result,
    output logic             illegal
);

    localparam logic [3:0] c_op_add  = 4'b0010;
    localparam logic [3:0] c_op_sub  = 4'b0110;
    localparam logic [6:0] c_f7_base = 7'b0000000;
    localparam logic [6:0] c_f7_alt  = 7'b0100000;

    logic [3:0] w_op;
    logic       w_ill;
    logic       w_mop;
    logic       w_take;
    logic       w_done;

    always_comb begin
        w_op  = c_op_add;
        w_ill = 1'b0;
        w_mop = 1'b0;
        case (ALUOp)
            2'b00: w_op = c_op_add;
            2'b01: w_op = c_op_sub;
            default: begin
                if (funct7 == c_f7_base) begin
                    case (funct3)
                        3'b000: w_op = 4'b0010;
                        3'b001: w_op = 4'b0100;
                        3'b010: w_op = 4'b1000;
                        3'b011: w_op = 4'b1001;
                        3'b100: w_op = 4'b0011;
                        3'b101: w_op = 4'b0101;
                        3'b110: w_op = 4'b0001;
                        3'b111: w_op = 4'b0000;
                        default: w_op = c_op_add;
                    endcase
                end else if (funct7 == c_f7_alt && funct3 == 3'b000) begin
                    w_op = c_op_sub;
                end else if (funct7 == c_f7_alt && funct3 == 3'b101) begin
                    w_op = 4'b0111;
`ifdef ALU_CTRL_MDU_EN
                end else if (funct7 == 7'b0000001 &&
                             (funct3 == 3'b000 || funct3 == 3'b101 || funct3 == 3'b111)) begin
                    w_mop = 1'b1;
`endif
                end else begin
                    w_ill = 1'b1;
                end
            end
        endcase
    end

    assign w_take = in_valid & in_ready & ~flush;

    // M-ops report through the completion path; everything else answers next cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            operation <= 4'b0000;
            md_sel    <= 1'b0;
            illegal   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (w_take && !w_mop) begin
            out_valid <= 1'b1;
            operation <= w_op;
            md_sel    <= 1'b0;
            illegal   <= w_ill;
        end else if (w_done) begin
            out_valid <= 1'b1;
            operation <= c_op_add;
            md_sel    <= 1'b1;
            illegal   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
        end
    end

`ifdef ALU_CTRL_MDU_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int              c_cw   = $clog2(WIDTH);
    localparam logic [c_cw-1:0] c_last = c_cw'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [c_cw-1:0]  r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [1:0]       r_kind;
    logic             w_last;
    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH-1:0] w_b_nxt;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_mul_sum;
    logic [WIDTH:0]   w_rsh;
    logic             w_borrow;

    assign in_ready = (r_state == S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: if (in_valid && !flush && w_mop) w_state_nxt = S_BUSY;
            S_BUSY: begin
                w_last = (r_cnt == c_last);
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush) w_state_nxt = S_IDLE;
    end

    assign w_done = w_last & ~flush;

    // r_kind: 00 MUL, 10 DIVU, 11 REMU. For divides r_a shifts dividend bits out
    // of the top while quotient bits enter at the bottom; r_acc is the remainder.
    always_comb begin
        w_mul_sum = r_b[0] ? (r_acc + r_a) : r_acc;
        w_rsh     = {r_acc, r_a[WIDTH-1]};
        w_borrow  = (w_rsh < {1'b0, r_b});
        if (r_kind[1]) begin
            w_a_nxt   = {r_a[WIDTH-2:0], ~w_borrow};
            w_b_nxt   = r_b;
            w_acc_nxt = w_borrow ? w_rsh[WIDTH-1:0] : (w_rsh[WIDTH-1:0] - r_b);
            w_res     = r_kind[0] ? w_acc_nxt : w_a_nxt;
        end else begin
            w_a_nxt   = {r_a[WIDTH-2:0], 1'b0};
            w_b_nxt   = {1'b0, r_b[WIDTH-1:1]};
            w_acc_nxt = w_mul_sum;
            w_res     = w_mul_sum;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_kind    <= 2'b00;
            md_result <= '0;
        end else if (!flush) begin
            if (r_state == S_IDLE && in_valid && w_mop) begin
                r_a    <= op_a;
                r_b    <= op_b;
                r_acc  <= '0;
                r_cnt  <= '0;
                r_kind <= {funct3[2], funct3[1]};
            end else if (r_state == S_BUSY) begin
                r_a   <= w_a_nxt;
                r_b   <= w_b_nxt;
                r_acc <= w_acc_nxt;
                r_cnt <= r_cnt + c_cw'(1);
                if (w_last) md_result <= w_res;
            end
        end
    end
`else
    logic w_unused;

    assign in_ready  = 1'b1;
    assign w_done    = 1'b0;
    assign md_result = '0;
    assign w_unused  = ^{op_a, op_b};
`endif

endmodule
`default_nettype wire
